muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-003 SHALL have port flush, input, 1: pipeline flush, aborts any operation in progress.
REQ-004 SHALL have port op_valid, input, 1: HI/LO operation request from the issue stage.
REQ-005 SHALL have port op, input, 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are accepted as no-ops.
REQ-006 SHALL have port src_a, input, 32: rs operand (dividend, multiplicand, MTHI/MTLO data).
REQ-007 SHALL have port src_b, input, 32: rt operand (divisor, multiplier).
REQ-008 SHALL have port hilo_read, input, 1: an MFHI/MFLO is in issue.
REQ-009 SHALL have ports hi and lo, output, 32 each: architectural HI/LO registers.
REQ-010 SHALL have port busy, output, 1: the state is not IDLE (combinational).
REQ-011 SHALL have port stall, output, 1: busy AND (op_valid OR hilo_read).
REQ-012 SHALL have port done, output, 1: pulses in the final busy cycle of a completing MUL/DIV.

Function
REQ-013 SHALL have states IDLE, MUL1, MUL2, DIV_ITER, DIV_FIX.
REQ-014 SHALL accept a request at cycle T only when the state is IDLE, op_valid=1 and flush=0; requests while busy are not accepted, and upstream holds them under stall.
REQ-015 MTHI/MTLO SHALL write src_a into hi/lo at the end of T, visible at T+1; the state stays IDLE.
REQ-016 MULT/MULTU SHALL latch operands at T and follow IDLE->MUL1->MUL2->IDLE, with busy high in T+1..T+2 and {hi,lo} = 64-bit signed/unsigned product visible at T+3.
REQ-017 DIV/DIVU SHALL latch operand magnitudes (signed ops: two's-complement absolute value) at T and run 32 restoring iterations in DIV_ITER (T+1..T+32, 5-bit counter), then do sign fix-up in DIV_FIX (T+33); lo=quotient and hi=remainder are visible at T+34.
REQ-018 Signed divide SHALL give a negative quotient iff operand signs differ, and the remainder SHALL take the dividend's sign.
REQ-019 0x80000000 / 0xFFFFFFFF (signed) SHALL yield lo=0x80000000, hi=0 with no exception.
REQ-020 A divisor of 0 SHALL yield hi=src_a and lo=0xFFFFFFFF for both DIV and DIVU, independent of signs.
REQ-021 A flush in any busy state SHALL return the state to IDLE on the next cycle with hi/lo unchanged and no done pulse.
REQ-022 flush coincident with the final busy cycle SHALL take priority: no hi/lo write, done=0.
REQ-023 flush coincident with op_valid in IDLE SHALL block acceptance, including for MTHI/MTLO.
REQ-024 A new request SHALL be acceptable in the first IDLE cycle after completion (back-to-back issue, no bubble).
REQ-025 Ops 6 and 7 SHALL cause no state or register change.

Reset
REQ-026 rst SHALL force the state to IDLE, the counter to 0, hi=0, lo=0 and operand/partial registers to 0 on the next edge; busy, stall and done are 0 the following cycle.
REQ-027 rst SHALL take priority over flush and op_valid, including mid-operation.

Configuration
REQ-028 Macro MULDIV_DIV_ZERO_SHORTCUT_EN SHALL, when defined, make a zero-divisor DIV/DIVU go IDLE->DIV_FIX->IDLE (busy at T+1 only, done at T+1, result visible at T+2).
REQ-029 Without MULDIV_DIV_ZERO_SHORTCUT_EN, a zero divisor SHALL take the full 33 busy cycles.
REQ-030 Results per REQ-020 SHALL be identical in both builds.

Verification
REQ-031 MULT src_a=0xFFFFFFFF, src_b=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE at T+3; done=1 at T+2; busy=1 at T+1..T+2.
REQ-032 MULTU src_a=0xFFFFFFFF, src_b=2 -> hi=0x00000001, lo=0xFFFFFFFE at T+3.
REQ-033 DIV src_a=0xFFFFFFF9 (-7), src_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF at T+34; DIVU 100/7 -> lo=14, hi=2.
REQ-034 DIVU src_a=7, src_b=0 -> hi=7, lo=0xFFFFFFFF at T+34 (at T+2 with MULDIV_DIV_ZERO_SHORTCUT_EN).
REQ-035 MTHI 0x12345678, then DIV, with flush at T+10 -> busy=0 at T+11, hi=0x12345678 and lo unchanged, done never asserted.
REQ-036 MTLO or hilo_read asserted while DIV is busy -> stall=1 each busy cycle, lo unchanged until acceptance at T+34.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide controller: 2-cycle multiply, 32-step restoring divide, MTHI/MTLO.
// Build option MULDIV_DIV_ZERO_SHORTCUT_EN: a zero-divisor DIV/DIVU skips the iteration phase.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hilo_read,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        done
);

  // state    | meaning
  // IDLE     | ready; accepts MUL/DIV, applies MTHI/MTLO directly
  // MUL1     | form 64-bit product from latched operands
  // MUL2     | commit product to HI/LO
  // DIV_ITER | one restoring step per cycle, 32 steps
  // DIV_FIX  | sign fix-up / divide-by-zero result, commit to HI/LO
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_MUL1     = 3'd1;
  localparam logic [2:0] S_MUL2     = 3'd2;
  localparam logic [2:0] S_DIV_ITER = 3'd3;
  localparam logic [2:0] S_DIV_FIX  = 3'd4;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic [2:0]  r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_signed;
  logic [63:0] r_prod;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_div_zero;

  logic        w_accept;
  logic        w_op_signed;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [2:0]  w_div_start;
  logic [63:0] w_a_ext;
  logic [63:0] w_b_ext;
  logic [32:0] w_rem_shift;
  logic [32:0] w_trial;
  logic        w_fits;
  logic [31:0] w_rem_next;
  logic [31:0] w_quo_next;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;
  logic [31:0] w_a_fix;

  assign hi    = r_hi;
  assign lo    = r_lo;
  assign busy  = (r_state != S_IDLE);
  assign stall = busy & (op_valid | hilo_read);
  assign done  = ((r_state == S_MUL2) || (r_state == S_DIV_FIX)) && !flush && !rst;

  assign w_accept    = (r_state == S_IDLE) && op_valid && !flush;
  assign w_op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign w_abs_a     = (w_op_signed && src_a[31]) ? (~src_a + 32'd1) : src_a;
  assign w_abs_b     = (w_op_signed && src_b[31]) ? (~src_b + 32'd1) : src_b;

`ifdef MULDIV_DIV_ZERO_SHORTCUT_EN
  assign w_div_start = (src_b == 32'd0) ? S_DIV_FIX : S_DIV_ITER;
`else
  assign w_div_start = S_DIV_ITER;
`endif

  // Sign-extend only for MULT; the low 64 bits of the 64x64 product are exact either way.
  assign w_a_ext = {{32{r_signed & r_a[31]}}, r_a};
  assign w_b_ext = {{32{r_signed & r_b[31]}}, r_b};

  // Remainder stays below the divisor, so bit 32 of the trial is a clean borrow flag.
  assign w_rem_shift = {r_rem, r_quo[31]};
  assign w_trial     = w_rem_shift - {1'b0, r_b};
  assign w_fits      = ~w_trial[32];
  assign w_rem_next  = w_fits ? w_trial[31:0] : w_rem_shift[31:0];
  assign w_quo_next  = {r_quo[30:0], w_fits};

  assign w_q_fix = r_neg_q ? (~r_quo + 32'd1) : r_quo;
  assign w_r_fix = r_neg_r ? (~r_rem + 32'd1) : r_rem;
  assign w_a_fix = r_neg_r ? (~r_a + 32'd1) : r_a;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 5'd0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_a        <= 32'd0;
      r_b        <= 32'd0;
      r_signed   <= 1'b0;
      r_prod     <= 64'd0;
      r_rem      <= 32'd0;
      r_quo      <= 32'd0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (op)
              OP_MTHI: r_hi <= src_a;
              OP_MTLO: r_lo <= src_a;
              OP_MULT, OP_MULTU: begin
                r_a      <= src_a;
                r_b      <= src_b;
                r_signed <= w_op_signed;
                r_state  <= S_MUL1;
              end
              OP_DIV, OP_DIVU: begin
                r_a        <= w_abs_a;
                r_b        <= w_abs_b;
                r_quo      <= w_abs_a;
                r_rem      <= 32'd0;
                r_cnt      <= 5'd31;
                r_signed   <= w_op_signed;
                r_neg_q    <= w_op_signed && (src_a[31] ^ src_b[31]);
                r_neg_r    <= w_op_signed && src_a[31];
                r_div_zero <= (src_b == 32'd0);
                r_state    <= w_div_start;
              end
              default: ;
            endcase
          end
        end
        S_MUL1: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_prod  <= w_a_ext * w_b_ext;
            r_state <= S_MUL2;
          end
        end
        S_MUL2: begin
          r_state <= S_IDLE;
          if (!flush) begin
            r_hi <= r_prod[63:32];
            r_lo <= r_prod[31:0];
          end
        end
        S_DIV_ITER: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            if (r_cnt == 5'd0) begin
              r_state <= S_DIV_FIX;
            end else begin
              r_cnt <= r_cnt - 5'd1;
            end
          end
        end
        S_DIV_FIX: begin
          r_state <= S_IDLE;
          if (!flush) begin
            // Zero divisor: HI gets the original dividend back, LO all ones, in either build.
            if (r_div_zero) begin
              r_hi <= w_a_fix;
              r_lo <= 32'hFFFF_FFFF;
            end else begin
              r_hi <= w_r_fix;
              r_lo <= w_q_fix;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: multiply/divide results and latency, flush, stall, reset.
module tb_muldiv_ctrl;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        hilo_read;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;

  muldiv_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .op_valid  (op_valid),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .hilo_read (hilo_read),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .stall     (stall),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance one cycle; registered outputs are stable afterwards.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Issue at the current cycle T and check latency, done pulse and result.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int lat;
    int dcnt;
    bit is_div;
    is_div = (o == 3'd2) || (o == 3'd3);
    lat = is_div ? 34 : 3;
`ifdef MULDIV_DIV_ZERO_SHORTCUT_EN
    if (is_div && (b == 32'd0)) lat = 2;
`endif
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    step();
    op_valid = 1'b0; src_a = 32'd0; src_b = 32'd0;
    #1;
    chk({tag, "_busy_t1"}, busy, 1);
    dcnt = done ? 1 : 0;
    for (int c = 2; c < lat; c++) begin
      step();
      if (done) dcnt++;
    end
    chk({tag, "_done_last"}, done, 1);
    step();
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_done_count"}, dcnt, 1);
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_lo"}, lo, elo);
  endtask

  task automatic write_hilo(input logic [2:0] o, input logic [31:0] a);
    op_valid = 1'b1; op = o; src_a = a;
    step();
    op_valid = 1'b0; src_a = 32'd0;
  endtask

  initial begin
    int dcnt;
    int scnt;
    rst = 1'b1; flush = 1'b0; op_valid = 1'b0; op = 3'd0;
    src_a = 32'd0; src_b = 32'd0; hilo_read = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);

    run_op("mult_neg", 3'd0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("mult_nn", 3'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'd0, 32'd15);
    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_100_7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_op("div_7_m2", 3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    run_op("divu_big", 3'd3, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF);
    run_op("divu_zero", 3'd3, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
    run_op("div_zero_neg", 3'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

    // MTHI/MTLO visible next cycle, state stays idle
    write_hilo(3'd5, 32'hA5A5_A5A5);
    chk("mtlo_lo", lo, 32'hA5A5_A5A5);
    write_hilo(3'd4, 32'h1234_5678);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_busy", busy, 0);

    // DIV flushed at T+10
    op_valid = 1'b1; op = 3'd2; src_a = 32'd50; src_b = 32'd3;
    step();
    op_valid = 1'b0;
    dcnt = done ? 1 : 0;
    for (int c = 2; c <= 10; c++) begin
      step();
      if (c == 10) flush = 1'b1;
      #1;
      if (done) dcnt++;
    end
    step();
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_hi", hi, 32'h1234_5678);
    chk("flush_lo", lo, 32'hA5A5_A5A5);
    chk("flush_done_count", dcnt, 0);

    // MTLO held under stall for a whole DIVU, accepted at T+34
    op_valid = 1'b1; op = 3'd3; src_a = 32'd100; src_b = 32'd7;
    step();
    op = 3'd5; src_a = 32'hDEAD_BEEF; src_b = 32'd0;
    #1;
    scnt = stall ? 1 : 0;
    for (int c = 2; c <= 33; c++) begin
      step();
      if (stall) scnt++;
      if (c == 33) chk("stall_lo_hold", lo, 32'hA5A5_A5A5);
    end
    chk("stall_cycles", scnt, 33);
    step();
    chk("stall_release", stall, 0);
    chk("stall_div_lo", lo, 32'd14);
    chk("stall_div_hi", hi, 32'd2);
    step();
    op_valid = 1'b0;
    chk("stall_mtlo_lo", lo, 32'hDEAD_BEEF);
    chk("stall_mtlo_busy", busy, 0);

    // hilo_read during MULT
    op_valid = 1'b1; op = 3'd0; src_a = 32'd6; src_b = 32'd7;
    step();
    op_valid = 1'b0; hilo_read = 1'b1;
    #1;
    chk("hr_stall_t1", stall, 1);
    step();
    chk("hr_stall_t2", stall, 1);
    step();
    chk("hr_stall_t3", stall, 0);
    chk("hr_lo", lo, 32'd42);
    hilo_read = 1'b0;

    // back-to-back: issue directly in the first idle cycle
    run_op("b2b_mult", 3'd1, 32'd3, 32'd4, 32'd0, 32'd12);
    run_op("b2b_divu", 3'd3, 32'd12, 32'd5, 32'd2, 32'd2);

    // flush coincident with the final MUL cycle
    op_valid = 1'b1; op = 3'd1; src_a = 32'd9; src_b = 32'd9;
    step();
    op_valid = 1'b0;
    step();
    flush = 1'b1;
    #1;
    chk("flush_last_done", done, 0);
    step();
    flush = 1'b0;
    chk("flush_last_busy", busy, 0);
    chk("flush_last_hi", hi, 32'd2);
    chk("flush_last_lo", lo, 32'd2);

    // flush with op_valid in IDLE blocks acceptance
    flush = 1'b1; op_valid = 1'b1; op = 3'd4; src_a = 32'hFFFF_0000;
    step();
    chk("flush_idle_mthi", hi, 32'd2);
    op = 3'd0; src_b = 32'd3;
    step();
    chk("flush_idle_mult", busy, 0);
    flush = 1'b0; op_valid = 1'b0;

    // ops 6 and 7 are no-ops
    op_valid = 1'b1; op = 3'd6; src_a = 32'h5555_5555; src_b = 32'd1;
    step();
    op = 3'd7;
    step();
    op_valid = 1'b0;
    chk("nop_busy", busy, 0);
    chk("nop_hi", hi, 32'd2);
    chk("nop_lo", lo, 32'd2);

    // reset mid-divide
    write_hilo(3'd4, 32'hCAFE_F00D);
    op_valid = 1'b1; op = 3'd2; src_a = 32'd1000; src_b = 32'd3;
    step();
    op_valid = 1'b0;
    for (int c = 2; c <= 5; c++) step();
    rst = 1'b1; flush = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
